// File: rtl/cvxif_copro_responder.sv
// cvxif_copro_responder
// Coprocessor-side responder for the CVXIF offload path. Offloaded custom-0
// instructions are queued in a small FIFO, executed one at a time in a
// fixed-latency unit, and returned in issue order on a one-cycle result strobe.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   flush_i                 drop every queued and in-flight offload
//   x_issue_valid_i/ready_o issue handshake
//   x_issue_accept_o        instruction is custom-0 (combinational decode)
//   x_off_instr_i           offloaded instruction word
//   x_trans_id_i            scoreboard transaction ID
//   x_rs1_i, x_rs2_i        source operands
//   x_result_*_o            registered writeback (valid, id, data, we, exc, exccode)
module cvxif_copro_responder #(
  parameter int XLEN          = 64,
  parameter int TRANS_ID_BITS = 3,
  parameter int DEPTH         = 4,
  parameter int LATENCY       = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     x_issue_valid_i,
  output logic                     x_issue_ready_o,
  output logic                     x_issue_accept_o,
  input  logic [31:0]              x_off_instr_i,
  input  logic [TRANS_ID_BITS-1:0] x_trans_id_i,
  input  logic [XLEN-1:0]          x_rs1_i,
  input  logic [XLEN-1:0]          x_rs2_i,
  output logic                     x_result_valid_o,
  output logic [TRANS_ID_BITS-1:0] x_result_id_o,
  output logic [XLEN-1:0]          x_result_data_o,
  output logic                     x_result_we_o,
  output logic                     x_result_exc_o,
  output logic [5:0]               x_result_exccode_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(LATENCY - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic            we;
    logic            exc;
    logic [XLEN-1:0] data;
  } res_t;

  // Result function of the custom-0 set; unknown funct3 returns tval.
  function automatic res_t exec_result(input logic [31:0] instr,
                                       input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
    res_t r;
    r.we   = 1'b1;
    r.exc  = 1'b0;
    r.data = '0;
    case (instr[14:12])
      3'b000:  r.data = a + b;
      3'b001:  r.data = a ^ b;
      3'b010:  r.data = a * b;
      3'b011:  r.we   = 1'b0;
      default: begin
        r.we   = 1'b0;
        r.exc  = 1'b1;
        r.data = XLEN'(instr);
      end
    endcase
    return r;
  endfunction

  logic [TRANS_ID_BITS-1:0] fifo_id    [DEPTH];
  logic [31:0]              fifo_instr [DEPTH];
  logic [XLEN-1:0]          fifo_rs1   [DEPTH];
  logic [XLEN-1:0]          fifo_rs2   [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_q;
  state_t           state_q, state_d;
  logic [LAT_W-1:0] cnt_q;
  logic             push, pop, fin;

  logic [TRANS_ID_BITS-1:0] id_p1;
  logic [31:0]              instr_p1;
  logic [XLEN-1:0]          rs1_p1, rs2_p1;
  res_t                     res_p1;

  logic                     vld_p2;
  logic [TRANS_ID_BITS-1:0] id_p2;
  logic [XLEN-1:0]          data_p2;
  logic                     we_p2, exc_p2;
  logic [5:0]               exccode_p2;

  assign x_issue_accept_o = (x_off_instr_i[6:0] == 7'h0B);
  assign x_issue_ready_o  = (count_q < DEPTH_C);
  assign push = x_issue_valid_i && x_issue_ready_o && x_issue_accept_o && !flush_i;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    fin     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          fin = 1'b1;
          if (count_q != '0) pop = 1'b1;
          else               state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d = IDLE;
      pop     = 1'b0;
      fin     = 1'b0;
    end
  end

  // Stage p0: FIFO storage
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_id[wr_ptr]    <= x_trans_id_i;
      fifo_instr[wr_ptr] <= x_off_instr_i;
      fifo_rs1[wr_ptr]   <= x_rs1_i;
      fifo_rs2[wr_ptr]   <= x_rs2_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (flush_i) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count_q <= count_q + CNT_W'(1);
          2'b01:   count_q <= count_q - CNT_W'(1);
          default: count_q <= count_q;
        endcase
      end
      if (pop)                                   cnt_q <= LAT_RELOAD;
      else if (state_q == BUSY && cnt_q != '0)   cnt_q <= cnt_q - LAT_W'(1);
    end
  end

  // Stage p1: execute register
  always_ff @(posedge clk_i) begin
    if (pop) begin
      id_p1    <= fifo_id[rd_ptr];
      instr_p1 <= fifo_instr[rd_ptr];
      rs1_p1   <= fifo_rs1[rd_ptr];
      rs2_p1   <= fifo_rs2[rd_ptr];
    end
  end

  assign res_p1 = exec_result(instr_p1, rs1_p1, rs2_p1);

  // Stage p2: registered writeback; outputs read zero out of reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p2     <= 1'b0;
      id_p2      <= '0;
      data_p2    <= '0;
      we_p2      <= 1'b0;
      exc_p2     <= 1'b0;
      exccode_p2 <= '0;
    end else begin
      vld_p2 <= fin;
      if (fin) begin
        id_p2      <= id_p1;
        data_p2    <= res_p1.data;
        we_p2      <= res_p1.we;
        exc_p2     <= res_p1.exc;
        exccode_p2 <= res_p1.exc ? 6'd2 : 6'd0;
      end
    end
  end

  assign x_result_valid_o   = vld_p2;
  assign x_result_id_o      = id_p2;
  assign x_result_data_o    = data_p2;
  assign x_result_we_o      = we_p2;
  assign x_result_exc_o     = exc_p2;
  assign x_result_exccode_o = exccode_p2;

endmodule

// File: tb/tb_cvxif_copro_responder.sv
// Testbench for cvxif_copro_responder: directed scenarios followed by random
// traffic, compared every cycle against a timestamp-based reference model.
module tb_cvxif_copro_responder;

  localparam int XLEN = 64;
  localparam int IDW  = 3;
  localparam int DEPTH = 4;
  localparam int LAT  = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            iv = 1'b0;
  logic            ready, accept;
  logic [31:0]     instr = '0;
  logic [IDW-1:0]  tid = '0;
  logic [XLEN-1:0] rs1 = '0, rs2 = '0;
  logic            rvalid, rwe, rexc;
  logic [IDW-1:0]  rid;
  logic [XLEN-1:0] rdata;
  logic [5:0]      rcode;

  always #5 clk = ~clk;

  cvxif_copro_responder #(.XLEN(XLEN), .TRANS_ID_BITS(IDW), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .x_issue_valid_i(iv), .x_issue_ready_o(ready), .x_issue_accept_o(accept),
    .x_off_instr_i(instr), .x_trans_id_i(tid), .x_rs1_i(rs1), .x_rs2_i(rs2),
    .x_result_valid_o(rvalid), .x_result_id_o(rid), .x_result_data_o(rdata),
    .x_result_we_o(rwe), .x_result_exc_o(rexc), .x_result_exccode_o(rcode));

  typedef struct {
    logic [IDW-1:0]  id;
    logic [31:0]     instr;
    logic [XLEN-1:0] a, b;
  } item_t;

  typedef struct {
    int              c;
    logic [IDW-1:0]  id;
    logic [XLEN-1:0] data;
    logic            we, exc;
    logic [5:0]      code;
  } exp_t;

  item_t pend[$];
  exp_t  expq[$];
  int    last_pop = -1000;
  int    cyc = 0;
  int    total = 0;
  int    bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic exp_t ref_result(input item_t it, input int c);
    exp_t e;
    e.c = c; e.id = it.id; e.we = 1'b1; e.exc = 1'b0; e.code = 6'd0; e.data = '0;
    case (it.instr[14:12])
      3'd0: e.data = it.a + it.b;
      3'd1: e.data = it.a ^ it.b;
      3'd2: e.data = it.a * it.b;
      3'd3: e.we = 1'b0;
      default: begin e.we = 1'b0; e.exc = 1'b1; e.code = 6'd2; e.data = {32'h0, it.instr}; end
    endcase
    return e;
  endfunction

  function automatic logic m_ready();
    return pend.size() < DEPTH;
  endfunction

  // Compare the outputs of the current cycle with the model.
  task automatic check_outputs();
    logic ev;
    ev = (expq.size() > 0) && (expq[0].c == cyc);
    chk("ready", ready, m_ready());
    chk("valid", rvalid, ev);
    if (ev) begin
      chk("id", rid, expq[0].id);
      chk("data", rdata, expq[0].data);
      chk("we", rwe, expq[0].we);
      chk("exc", rexc, expq[0].exc);
      chk("exccode", rcode, expq[0].code);
      void'(expq.pop_front());
    end
  endtask

  // One clock cycle: check, drive, advance model, step clock.
  task automatic step(input logic v, input logic [31:0] ins, input logic [IDW-1:0] id,
                      input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic fl);
    logic rdy, acc;
    item_t it;
    check_outputs();
    rdy = m_ready();
    iv = v; instr = ins; tid = id; rs1 = a; rs2 = b; flush = fl;
    #1;
    acc = (ins[6:0] == 7'h0B);
    chk("accept", accept, acc);
    if (fl) begin
      pend.delete();
      expq.delete();
      last_pop = -1000;
    end else begin
      if (pend.size() > 0 && cyc >= last_pop + LAT) begin
        expq.push_back(ref_result(pend.pop_front(), cyc + LAT + 1));
        last_pop = cyc;
      end
      if (v && rdy && acc) begin
        it.id = id; it.instr = ins; it.a = a; it.b = b;
        pend.push_back(it);
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, '0, '0, '0, 1'b0);
  endtask

  // Offer the same request until it is taken (bounded).
  task automatic offer(input logic [31:0] ins, input logic [IDW-1:0] id,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic taken;
    taken = 1'b0;
    for (int t = 0; t < 40 && !taken; t++) begin
      taken = m_ready();
      step(1'b1, ins, id, a, b, 1'b0);
    end
    chk("offer_taken", taken, 1'b1);
  endtask

  task automatic zero_outputs(input string tag);
    chk({tag, "_valid"}, rvalid, 1'b0);
    chk({tag, "_id"}, rid, '0);
    chk({tag, "_data"}, rdata, '0);
    chk({tag, "_we"}, rwe, 1'b0);
    chk({tag, "_exc"}, rexc, 1'b0);
    chk({tag, "_exccode"}, rcode, '0);
    chk({tag, "_ready"}, ready, 1'b1);
  endtask

  task automatic mid_reset();
    check_outputs();
    iv = 1'b0; flush = 1'b0;
    rst_n = 1'b0;
    #1;
    zero_outputs("async_rst");
    pend.delete(); expq.delete(); last_pop = -1000;
    @(posedge clk); #1;
    cyc++;
    zero_outputs("in_rst");
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] ri;
    logic [2:0]  f3;
    #1;
    zero_outputs("reset");
    instr = 32'h0000000B; #1;
    chk("accept_in_reset", accept, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    idle(3);
    // ADD with wraparound: all-ones + 2 = 1
    step(1'b1, 32'h0000000B, 3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0);
    idle(6);

    // back-to-back MUL fill
    for (int k = 0; k < 5; k++) offer(32'h0000200B, IDW'(k), 64'd3, 64'd7);
    idle(14);

    // illegal funct3, non-custom opcode, NOP
    offer(32'h0000700B, 3'd2, 64'h1234, 64'h5678);
    step(1'b1, 32'h00000033, 3'd6, 64'd1, 64'd1, 1'b0);
    offer(32'h0000300B, 3'd3, 64'd9, 64'd9);
    offer(32'h0000100B, 3'd4, 64'hF0F0, 64'h0FF0);
    idle(8);

    // flush with a full queue and a busy unit
    for (int k = 0; k < 5; k++) step(1'b1, 32'h0000000B, IDW'(k), 64'(k), 64'd100, 1'b0);
    step(1'b0, 32'h0, '0, '0, '0, 1'b1);
    idle(1);
    step(1'b1, 32'h0000000B, 3'd7, 64'd40, 64'd2, 1'b0);
    idle(6);

    // reset while busy
    step(1'b1, 32'h0000000B, 3'd1, 64'd1, 64'd1, 1'b0);
    step(1'b1, 32'h0000200B, 3'd2, 64'd5, 64'd5, 1'b0);
    idle(1);
    mid_reset();
    idle(8);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      f3 = 3'($urandom_range(0, 7));
      ri = $urandom();
      ri[14:12] = f3;
      ri[6:0] = ($urandom_range(0, 9) == 0) ? 7'h33 : 7'h0B;
      step(1'($urandom_range(0, 3) != 0), ri, IDW'($urandom()),
           {$urandom(), $urandom()}, {$urandom(), $urandom()},
           ($urandom_range(0, 59) == 0));
    end
    idle(20);
    chk("all_results_seen", 64'(expq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
